slider_cmd_gen: RTL and testbench
=================================

// Module: slider_cmd_gen
// PURPOSE
//  Input-conditioning stage directly upstream of the slider position register.
//  Turns four raw active-low push-buttons into single-cycle move strobes (go/back/up/down).
//  Per key: synchronise, then debounce. Per axis: resolve conflicts, then apply auto-repeat
//  (immediate step on press, slow repeat while held, fast repeat after a long hold).
//  Without this stage the slider would move 1 px per pixel clock while a key is held.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000    consecutive stable cycles before a debounced level changes (10 ms @25 MHz)
//  SLOW_PERIOD      250000    repeat interval in SLOW state, in cycles (100 px/s)
//  FAST_PERIOD      62500     repeat interval in FAST state, in cycles (400 px/s)
//  ACCEL_DELAY      12500000  hold time from first strobe until SLOW->FAST, in cycles (0.5 s)
//  CNT_W            24        width of all internal counters; must hold max(parameters)
// PORTS
//  iVGA_CLK       in   1  pixel clock; all logic on its rising edge
//  iRST_n         in   1  reset, asynchronous assert, active-low
//  iKEY_n         in   4  raw buttons, active-low, asynchronous; [0]=go [1]=back [2]=up [3]=down
//  iEnable        in   1  game-running qualifier; low suppresses all strobes
//  oSlider_go     out  1  one-cycle strobe, +1 x
//  oSlider_back   out  1  one-cycle strobe, -1 x
//  oSlider_up     out  1  one-cycle strobe, -1 y
//  oSlider_down   out  1  one-cycle strobe, +1 y
//  oKey_state     out  4  debounced pressed levels, active-high, same bit order as iKEY_n
// BEHAVIOUR
//  - Reset: all strobes 0, oKey_state 4'b0000 (released), sync FFs =1, counters 0, axis FSMs IDLE.
//    Reset mid-hold aborts the hold. After release of reset, a key that is still held
//    re-qualifies through the full debounce before it has any effect.
//  - Sync: 2-FF synchroniser per key. Inversion happens after synchronisation.
//  - Debounce, per key:
//    - The counter clears whenever the synced level equals oKey_state.
//    - Otherwise the counter increments. On the cycle it reaches DEBOUNCE_CYCLES-1,
//      oKey_state toggles and the counter clears.
//    - Any glitch shorter than DEBOUNCE_CYCLES never reaches oKey_state.
//  - Axis direction, derived from oKey_state:
//    - X: go only = +, back only = -, none or both = 0.
//    - Y: up only = -, down only = +, none or both = 0.
//    - The two axes are fully independent; diagonal moves are legal.
//  - Axis FSM (one per axis; states IDLE, SLOW, FAST), registered outputs:
//    - IDLE, dir!=0 (and iEnable): strobe for dir in the next cycle; period_cnt=0, hold_cnt=0; go to SLOW.
//    - SLOW: period_cnt increments. At SLOW_PERIOD-1: strobe, period_cnt=0.
//      hold_cnt saturates at ACCEL_DELAY-1; on reaching it go to FAST with period_cnt=0.
//    - FAST: same repeat rule as SLOW, using FAST_PERIOD.
//    - Any state, dir==0: go to IDLE next cycle. No strobe on release.
//    - SLOW/FAST, dir changes to the opposite non-zero value: treated as a new press.
//      Immediate strobe for the new dir, counters cleared, state SLOW.
//    - iEnable low: FSMs forced IDLE, strobes 0. Counters and debounce keep running.
//      When iEnable rises with a key held, this is a new press (immediate strobe).
//  - Strobe rules:
//    - At most one of go/back and at most one of up/down is high in any cycle.
//    - A strobe is never high for two consecutive cycles.
//  - Latency: debounced press to first strobe = 1 cycle.
//    Raw edge to oKey_state = 2 (sync) + DEBOUNCE_CYCLES cycles.
//  - Counters are unsigned CNT_W bits and never wrap. Parameters are all >=2.
// STRUCTURE
//  - setting.v holds the default constants (KEY_DEBOUNCE_CYCLES, SLIDER_SLOW_PERIOD,
//    SLIDER_FAST_PERIOD, SLIDER_ACCEL_DELAY) and the key-bit index constants.
//  - Sub-module key_debounce: sync plus debounce for one key, instantiated 4x (generate loop).
//    It has parameters DEBOUNCE_CYCLES and CNT_W, and exposes a clean level.
//  - The two axis FSMs are written inline as two copies of identical logic.
// TESTING  (sim parameters: DEBOUNCE_CYCLES=4, SLOW_PERIOD=10, FAST_PERIOD=3, ACCEL_DELAY=30)
//  1. Key0 toggles every 2 cycles for 20 cycles, then is held low.
//     -> Exactly one oKey_state[0] rise, 6 cycles after the final edge.
//     -> One oSlider_go strobe 1 cycle after that rise. No strobes during the bounce.
//  2. Hold key0 for 80 cycles past debounce.
//     -> go strobes at t=1,11,21,31; FAST from t=31; then strobes every 3 cycles.
//     -> Release: no further strobes after the FSM reaches IDLE.
//  3. Hold key0 and key1 together, while key2 is held.
//     -> No go/back strobes. Up strobes follow the test-2 schedule.
//  4. Hold key0 in FAST, then switch to key1 (key0 debounced off and key1 on in the same cycle).
//     -> Immediate back strobe, then the back strobe 10 cycles later (SLOW).
//  5. Hold key3 with iEnable=0 for 50 cycles, then raise iEnable.
//     -> No strobes while iEnable=0; down strobe 1 cycle after the rise.
//  6. Assert iRST_n=0 mid-FAST for 3 cycles, key still held.
//     -> Outputs 0 immediately; after reset, first strobe only after re-debounce (t=2+4+1).

Source files
------------

// File: rtl/slider_cmd_gen_pkg.sv
// ---------------------------------------------------------------------------
// slider_cmd_gen_pkg
//   Shared constants and types for the slider command generator:
//   default timing constants, key bit positions within iKEY_n / oKey_state,
//   axis FSM state and direction encodings, and the per-axis direction
//   resolver used by both axis FSMs.
// ---------------------------------------------------------------------------
package slider_cmd_gen_pkg;

  // Default timing at a 25 MHz pixel clock
  localparam int KEY_DEBOUNCE_CYCLES = 250000;    // 10 ms
  localparam int SLIDER_SLOW_PERIOD  = 250000;    // 100 px/s
  localparam int SLIDER_FAST_PERIOD  = 62500;     // 400 px/s
  localparam int SLIDER_ACCEL_DELAY  = 12500000;  // 0.5 s
  localparam int SLIDER_CNT_W        = 24;

  // Key bit positions
  localparam int KEY_GO   = 0;
  localparam int KEY_BACK = 1;
  localparam int KEY_UP   = 2;
  localparam int KEY_DOWN = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } axis_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10
  } axis_dir_e;

  // Both keys of an axis pressed cancel each other out.
  function automatic axis_dir_e resolve_dir(input logic pos, input logic neg);
    case ({pos, neg})
      2'b10:   return DIR_POS;
      2'b01:   return DIR_NEG;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/slider_cmd_gen_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//   Synchronises one raw active-low push-button into iVGA_CLK and debounces
//   it into a clean active-high pressed level.
//   Ports:
//     iVGA_CLK  in  pixel clock
//     iRST_n    in  asynchronous active-low reset
//     iKEY_n    in  raw button, active-low, asynchronous
//     oPressed  out debounced pressed level (1 = pressed)
// ---------------------------------------------------------------------------
module key_debounce
  import slider_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int CNT_W           = SLIDER_CNT_W
) (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic iKEY_n,
  output logic oPressed
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_sync;

  always_comb begin
    sync1_d      = iKEY_n;
    sync2_d      = sync1_q;
    // Invert only after the second flop so the synchroniser sees the raw pin.
    pressed_sync = ~sync2_q;
    state_d      = state_q;
    cnt_d        = '0;
    // The counter measures how long the synced level has disagreed with the
    // debounced level; any agreement restarts the measurement.
    if (pressed_sync != state_q) begin
      if (cnt_q == DB_LAST) begin
        state_d = ~state_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oPressed = state_q;

endmodule

// File: rtl/slider_cmd_gen.sv
// ---------------------------------------------------------------------------
// slider_cmd_gen
//   Input conditioning in front of the slider position register. Four raw
//   buttons are synchronised and debounced, resolved per axis, and turned
//   into single-cycle move strobes with auto-repeat (step on press, slow
//   repeat while held, fast repeat after a long hold).
//   Ports:
//     iVGA_CLK      in  pixel clock, rising edge
//     iRST_n        in  asynchronous active-low reset
//     iKEY_n[3:0]   in  raw buttons, active-low: [0]go [1]back [2]up [3]down
//     iEnable       in  game running; low suppresses all strobes
//     oSlider_go    out strobe, +1 x
//     oSlider_back  out strobe, -1 x
//     oSlider_up    out strobe, -1 y
//     oSlider_down  out strobe, +1 y
//     oKey_state    out debounced pressed levels, active-high
// ---------------------------------------------------------------------------
module slider_cmd_gen
  import slider_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int SLOW_PERIOD     = SLIDER_SLOW_PERIOD,
  parameter int FAST_PERIOD     = SLIDER_FAST_PERIOD,
  parameter int ACCEL_DELAY     = SLIDER_ACCEL_DELAY,
  parameter int CNT_W           = SLIDER_CNT_W
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [3:0] iKEY_n,
  input  logic       iEnable,
  output logic       oSlider_go,
  output logic       oSlider_back,
  output logic       oSlider_up,
  output logic       oSlider_down,
  output logic [3:0] oKey_state
);

  localparam logic [CNT_W-1:0] SLOW_LAST  = CNT_W'(SLOW_PERIOD - 1);
  localparam logic [CNT_W-1:0] FAST_LAST  = CNT_W'(FAST_PERIOD - 1);
  localparam logic [CNT_W-1:0] ACCEL_LAST = CNT_W'(ACCEL_DELAY - 1);

  logic [3:0] key_state;
  logic [1:0] axis_pos;    // [0] = x (go),   [1] = y (down)
  logic [1:0] axis_neg;    // [0] = x (back), [1] = y (up)
  logic [1:0] strobe_pos;
  logic [1:0] strobe_neg;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key (
      .iVGA_CLK(iVGA_CLK),
      .iRST_n  (iRST_n),
      .iKEY_n  (iKEY_n[k]),
      .oPressed(key_state[k])
    );
  end

  assign axis_pos = {key_state[KEY_DOWN], key_state[KEY_GO]};
  assign axis_neg = {key_state[KEY_UP],   key_state[KEY_BACK]};

  // One identical repeat FSM per axis; the axes never interact.
  for (genvar a = 0; a < 2; a++) begin : g_axis
    axis_state_e      state_q, state_d;
    axis_dir_e        dir_q, dir_d, dir_in;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] period_last;
    logic             sp_q, sp_d;
    logic             sn_q, sn_d;

    assign dir_in      = resolve_dir(axis_pos[a], axis_neg[a]);
    assign period_last = (state_q == ST_FAST) ? FAST_LAST : SLOW_LAST;

    always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      period_d = period_q;
      hold_d   = hold_q;
      sp_d     = 1'b0;
      sn_d     = 1'b0;
      if (!iEnable || dir_in == DIR_NONE) begin
        state_d = ST_IDLE;
      end else if (state_q == ST_IDLE || dir_in != dir_q) begin
        // Fresh press, or a reversal which counts as a fresh press.
        state_d  = ST_SLOW;
        dir_d    = dir_in;
        period_d = '0;
        hold_d   = '0;
        sp_d     = (dir_in == DIR_POS);
        sn_d     = (dir_in == DIR_NEG);
      end else begin
        if (period_q == period_last) begin
          period_d = '0;
          sp_d     = (dir_q == DIR_POS);
          sn_d     = (dir_q == DIR_NEG);
        end else begin
          period_d = period_q + CNT_W'(1);
        end
        // hold_cnt only advances in SLOW; once it tops out we move to FAST
        // and restart the period so the fast cadence starts cleanly.
        if (state_q == ST_SLOW) begin
          if (hold_q == ACCEL_LAST) begin
            state_d  = ST_FAST;
            period_d = '0;
          end else begin
            hold_d = hold_q + CNT_W'(1);
          end
        end
      end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
        state_q  <= ST_IDLE;
        dir_q    <= DIR_NONE;
        period_q <= '0;
        hold_q   <= '0;
        sp_q     <= 1'b0;
        sn_q     <= 1'b0;
      end else begin
        state_q  <= state_d;
        dir_q    <= dir_d;
        period_q <= period_d;
        hold_q   <= hold_d;
        sp_q     <= sp_d;
        sn_q     <= sn_d;
      end
    end

    assign strobe_pos[a] = sp_q;
    assign strobe_neg[a] = sn_q;
  end

  assign oSlider_go   = strobe_pos[0];
  assign oSlider_back = strobe_neg[0];
  assign oSlider_down = strobe_pos[1];
  assign oSlider_up   = strobe_neg[1];
  assign oKey_state   = key_state;

endmodule

// File: tb/tb_slider_cmd_gen.sv
// ---------------------------------------------------------------------------
// tb_slider_cmd_gen
//   Self-checking bench for slider_cmd_gen with short timing parameters
//   (debounce 4, slow 10, fast 3, accel 30). Hand-written sequences cover
//   bounce rejection, the repeat schedule, axis conflicts, reversal, enable
//   gating and reset mid-hold; a vector table covers steady key patterns.
// ---------------------------------------------------------------------------
module tb_slider_cmd_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic       en = 1'b1;
  logic       go, back, up, down;
  logic [3:0] ks;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int viol = 0;

  int go_q[$];
  int back_q[$];
  int up_q[$];
  int down_q[$];
  int ks0_rise_q[$];

  logic [3:0] prev_str = 4'b0;
  logic       prev_ks0 = 1'b0;

  typedef struct {
    logic [3:0] key_n;
    logic       en;
    int         n;
    logic [3:0] ks_exp;
    int         go;
    int         back;
    int         up;
    int         down;
  } vec_t;

  vec_t tbl[10];

  slider_cmd_gen #(
    .DEBOUNCE_CYCLES(4),
    .SLOW_PERIOD    (10),
    .FAST_PERIOD    (3),
    .ACCEL_DELAY    (30),
    .CNT_W          (24)
  ) dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rst_n),
    .iKEY_n      (key_n),
    .iEnable     (en),
    .oSlider_go  (go),
    .oSlider_back(back),
    .oSlider_up  (up),
    .oSlider_down(down),
    .oKey_state  (ks)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe and key-state logging, sampled away from the active edge.
  always @(negedge clk) begin
    if (go)   go_q.push_back(cyc);
    if (back) back_q.push_back(cyc);
    if (up)   up_q.push_back(cyc);
    if (down) down_q.push_back(cyc);
    if (ks[0] && !prev_ks0) ks0_rise_q.push_back(cyc);
    viol <= viol + int'((go && back) || (up && down))
                 + int'(|({go, back, up, down} & prev_str));
    prev_str <= {go, back, up, down};
    prev_ks0 <= ks[0];
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int count_in(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
    return n;
  endfunction

  function automatic int nth_at(input int q[$], input int lo, input int k);
    int n = 0;
    foreach (q[i]) begin
      if (q[i] >= lo) begin
        if (n == k) return q[i];
        n++;
      end
    end
    return -1;
  endfunction

  initial begin
    int e, t0, s, r, q, rel, start;
    int exp_q[$];
    logic [3:0] ks_or;

    //            key_n    en    n   ks_exp   go back up down
    tbl[0] = '{4'b1110, 1'b1, 15, 4'b0001, 2, 0, 0, 0};
    tbl[1] = '{4'b1101, 1'b1, 25, 4'b0010, 0, 3, 0, 0};
    tbl[2] = '{4'b1011, 1'b1,  5, 4'b0100, 0, 0, 1, 0};
    tbl[3] = '{4'b0111, 1'b1, 40, 4'b1000, 0, 0, 0, 7};
    tbl[4] = '{4'b1010, 1'b1, 12, 4'b0101, 2, 0, 2, 0};
    tbl[5] = '{4'b0101, 1'b1,  3, 4'b0000, 0, 0, 0, 0};
    tbl[6] = '{4'b0000, 1'b1, 20, 4'b1111, 0, 0, 0, 0};
    tbl[7] = '{4'b1110, 1'b0, 20, 4'b0001, 0, 0, 0, 0};
    tbl[8] = '{4'b0100, 1'b1, 11, 4'b1011, 0, 0, 0, 2};
    tbl[9] = '{4'b1110, 1'b1,  4, 4'b0001, 1, 0, 0, 0};

    // Reset state
    step(3);
    check("reset_strobes", int'({go, back, up, down}), 0);
    check("reset_key_state", int'(ks), 0);
    rst_n = 1'b1;
    step(2);

    // Bouncing go key, then a solid press
    start = cyc;
    for (int i = 0; i < 10; i++) begin
      key_n[0] = i[0];
      step(2);
    end
    key_n[0] = 1'b0;
    e = cyc;
    step(10);
    check("bounce_ks0_rises", count_in(ks0_rise_q, start, cyc), 1);
    check("bounce_ks0_rise_time", nth_at(ks0_rise_q, start, 0), e + 6);
    check("bounce_no_go", count_in(go_q, start, e + 6), 0);
    check("bounce_first_go", nth_at(go_q, start, 0), e + 7);

    // Long hold: slow repeat, then fast repeat, then release
    t0 = e + 6;
    step(t0 + 80 - cyc);
    key_n[0] = 1'b1;
    step(30);
    exp_q = {t0 + 1, t0 + 11, t0 + 21};
    for (int k = 0; k <= 18; k++) exp_q.push_back(t0 + 31 + 3 * k);
    check("hold_go_count", count_in(go_q, t0, cyc), exp_q.size());
    foreach (exp_q[i]) check($sformatf("hold_go_%0d", i), nth_at(go_q, t0, i), exp_q[i]);
    check("hold_released_ks", int'(ks), 0);
    check("hold_no_go_after_idle", count_in(go_q, t0 + 87, cyc), 0);

    // go+back cancel while up repeats on its own
    start = cyc;
    key_n = 4'b1000;
    step(6);
    t0 = cyc;
    check("conflict_ks", int'(ks), 4'b0111);
    step(40);
    key_n = 4'hF;
    step(15);
    exp_q = {t0 + 1, t0 + 11, t0 + 21, t0 + 31, t0 + 34, t0 + 37, t0 + 40, t0 + 43, t0 + 46};
    check("conflict_up_count", count_in(up_q, start, cyc), exp_q.size());
    foreach (exp_q[i]) check($sformatf("conflict_up_%0d", i), nth_at(up_q, start, i), exp_q[i]);
    check("conflict_no_x", count_in(go_q, start, cyc) + count_in(back_q, start, cyc), 0);

    // Reversal from go (FAST) to back in a single cycle
    start = cyc;
    key_n = 4'b1110;
    t0 = start + 6;
    step(46);
    s = cyc;
    key_n = 4'b1101;
    step(20);
    key_n = 4'hF;
    step(15);
    check("reverse_go_before", count_in(go_q, t0, s + 6), 9);
    check("reverse_go_after", count_in(go_q, s + 7, cyc), 0);
    check("reverse_back_count", count_in(back_q, start, cyc), 2);
    check("reverse_back_0", nth_at(back_q, start, 0), s + 7);
    check("reverse_back_1", nth_at(back_q, start, 1), s + 17);

    // Down held while disabled, then enable rises
    en = 1'b0;
    start = cyc;
    key_n = 4'b0111;
    step(50);
    r = cyc;
    check("enable_ks_tracks", int'(ks), 4'b1000);
    check("enable_no_down", count_in(down_q, start, r), 0);
    en = 1'b1;
    step(12);
    key_n = 4'hF;
    step(15);
    check("enable_down_count", count_in(down_q, start, cyc), 2);
    check("enable_down_0", nth_at(down_q, start, 0), r + 1);
    check("enable_down_1", nth_at(down_q, start, 1), r + 11);

    // Reset in the middle of a FAST hold
    start = cyc;
    key_n = 4'b1110;
    t0 = start + 6;
    step(47);
    q = cyc;
    check("rst_fast_reached", count_in(go_q, t0 + 31, q), 4);
    rst_n = 1'b0;
    #1;
    check("rst_async_strobes", int'({go, back, up, down}), 0);
    check("rst_async_ks", int'(ks), 0);
    step(3);
    rst_n = 1'b1;
    rel = cyc;
    step(12);
    check("rst_no_go_during", count_in(go_q, q, rel), 0);
    check("rst_ks0_rise", nth_at(ks0_rise_q, q, 0), rel + 6);
    check("rst_first_go", nth_at(go_q, q, 0), rel + 7);
    key_n = 4'hF;
    step(15);

    // Table of steady key patterns: hold n cycles, release, let it settle
    foreach (tbl[i]) begin
      en    = tbl[i].en;
      key_n = tbl[i].key_n;
      s     = cyc;
      ks_or = 4'b0;
      for (int c = 0; c < tbl[i].n; c++) begin
        step(1);
        ks_or |= ks;
      end
      key_n = 4'hF;
      for (int c = 0; c < 12; c++) begin
        step(1);
        ks_or |= ks;
      end
      e = cyc;
      check($sformatf("row%0d_ks", i), int'(ks_or), int'(tbl[i].ks_exp));
      check($sformatf("row%0d_go", i), count_in(go_q, s, e), tbl[i].go);
      check($sformatf("row%0d_back", i), count_in(back_q, s, e), tbl[i].back);
      check($sformatf("row%0d_up", i), count_in(up_q, s, e), tbl[i].up);
      check($sformatf("row%0d_down", i), count_in(down_q, s, e), tbl[i].down);
      en = 1'b1;
    end

    step(2);
    check("strobe_rules", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
